// File: rtl/fc_lif_accum_if.sv
// fc_lif_accum_if
//   Bundles every non-clock/reset signal of fc_lif_accum.
//   slave  : the fc_lif_accum side (strobes, weight data and buffer reads in;
//            weight read request, lane spikes, buffer row and status out).
//   master : the upstream/environment side (the exact mirror).
//   Upstream strobes:  en_accum, spk_addr, neuron, en_activ, spk_time_step,
//                      last_time_step, post_syn_RAM_loaded
//   Weight RAM:        w_rd_en, w_addr, w_data (valid one cycle after w_rd_en)
//   Spike buffer read: spk_out_rd_en, spk_out_rd_addr, spk_out_train
//   Status:            post_syn_spk, layer_spks_ready, total_out_spks
interface fc_lif_accum_if #(
  parameter int TIME_STEPS   = 10,
  parameter int EC_SIZE      = 4,
  parameter int LAYER_SIZE   = 32,
  parameter int SPARSE_SIZE  = 240,
  parameter int WEIGHT_WIDTH = 8
);
  localparam int NGROUPS = LAYER_SIZE / EC_SIZE;
  localparam int AW      = $clog2(SPARSE_SIZE);
  localparam int NW      = $clog2(LAYER_SIZE);
  localparam int TW      = $clog2(TIME_STEPS) + 2;
  localparam int WAW     = $clog2(NGROUPS * SPARSE_SIZE);
  localparam int RAW     = $clog2(TIME_STEPS);

  logic                            en_accum;
  logic [AW-1:0]                   spk_addr;
  logic [NW-1:0]                   neuron;
  logic                            en_activ;
  logic [TW-1:0]                   spk_time_step;
  logic                            last_time_step;
  logic                            post_syn_RAM_loaded;
  logic                            w_rd_en;
  logic [WAW-1:0]                  w_addr;
  logic [EC_SIZE*WEIGHT_WIDTH-1:0] w_data;
  logic [EC_SIZE-1:0]              post_syn_spk;
  logic                            spk_out_rd_en;
  logic [RAW-1:0]                  spk_out_rd_addr;
  logic [LAYER_SIZE-1:0]           spk_out_train;
  logic                            layer_spks_ready;
  logic [31:0]                     total_out_spks;

  modport slave (
    input  en_accum, spk_addr, neuron, en_activ, spk_time_step, last_time_step,
           post_syn_RAM_loaded, w_data, spk_out_rd_en, spk_out_rd_addr,
    output w_rd_en, w_addr, post_syn_spk, spk_out_train, layer_spks_ready,
           total_out_spks
  );

  modport master (
    output en_accum, spk_addr, neuron, en_activ, spk_time_step, last_time_step,
           post_syn_RAM_loaded, w_data, spk_out_rd_en, spk_out_rd_addr,
    input  w_rd_en, w_addr, post_syn_spk, spk_out_train, layer_spks_ready,
           total_out_spks
  );
endinterface

// File: rtl/fc_lif_accum.sv
// fc_lif_accum
//   Weighted membrane accumulation and leaky integrate-and-fire for one group
//   of EC_SIZE neurons, with a TIME_STEPS x LAYER_SIZE output spike buffer.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset; clears all state including buffer
//     bus  - fc_lif_accum_if.slave (upstream strobes, weight RAM, buffer read,
//            status outputs)
//   Pipeline: cycle N strobe -> N+1 weight read issued -> N+2 weight lands in
//   acc. Activation controls ride a matching 2-cycle delay so an accumulate and
//   an activation issued together see the accumulate first.
module fc_lif_accum #(
  parameter int TIME_STEPS   = 10,
  parameter int EC_SIZE      = 4,
  parameter int LAYER_SIZE   = 32,
  parameter int SPARSE_SIZE  = 240,
  parameter int WEIGHT_WIDTH = 8,
  parameter int MEM_WIDTH    = 16,
  parameter int THRESHOLD    = 64,
  parameter int LEAK_SHIFT   = 3
) (
  input logic           clk,
  input logic           rst,
  fc_lif_accum_if.slave bus
);
  localparam int NGROUPS = LAYER_SIZE / EC_SIZE;
  localparam int NW      = $clog2(LAYER_SIZE);
  localparam int TW      = $clog2(TIME_STEPS) + 2;
  localparam int WAW     = $clog2(NGROUPS * SPARSE_SIZE);
  localparam int RAW     = $clog2(TIME_STEPS);
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  localparam logic signed [MEM_WIDTH-1:0] MEM_MAX = {1'b0, {(MEM_WIDTH-1){1'b1}}};
  localparam logic signed [MEM_WIDTH-1:0] MEM_MIN = {1'b1, {(MEM_WIDTH-1){1'b0}}};
  localparam logic signed [MEM_WIDTH-1:0] THR     = MEM_WIDTH'(THRESHOLD);

  // Delayed control, aligned with the cycle the weight word is on w_data.
  logic          acc_vld;
  logic [1:0]    activ_d;
  logic [1:0]    last_d;
  logic [TW-1:0] t_d1, t_d2;
  logic [NW-1:0] g_d1, g_d2;

  logic signed [MEM_WIDTH-1:0] acc_q [EC_SIZE];
  logic signed [MEM_WIDTH-1:0] v_q   [EC_SIZE];

  logic signed [MEM_WIDTH:0]   acc_wide [EC_SIZE];
  logic signed [MEM_WIDTH-1:0] acc_sum  [EC_SIZE];
  logic signed [MEM_WIDTH+1:0] v_wide   [EC_SIZE];
  logic signed [MEM_WIDTH-1:0] v_sat    [EC_SIZE];
  logic signed [MEM_WIDTH-1:0] v_fire   [EC_SIZE];
  logic [EC_SIZE-1:0]          spike;

  logic [LAYER_SIZE-1:0] spk_buf [TIME_STEPS];
  logic                  buf_wr;
  logic [RAW-1:0]        wr_row;
  logic [GW-1:0]         wr_grp;
  logic                  rd_in_range;

  logic       ld_prev;
  logic [1:0] ld_pipe;

  // Stage 0: weight read request plus the control delay line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.w_rd_en <= 1'b0;
      bus.w_addr  <= '0;
      acc_vld     <= 1'b0;
      activ_d     <= '0;
      last_d      <= '0;
      t_d1        <= '0;
      t_d2        <= '0;
      g_d1        <= '0;
      g_d2        <= '0;
    end else begin
      bus.w_rd_en <= bus.en_accum;
      if (bus.en_accum)
        bus.w_addr <= WAW'(32'(bus.neuron) * 32'(SPARSE_SIZE) + 32'(bus.spk_addr));
      acc_vld <= bus.w_rd_en;
      activ_d <= {activ_d[0], bus.en_activ};
      last_d  <= {last_d[0], bus.last_time_step};
      t_d1    <= bus.spk_time_step;
      t_d2    <= t_d1;
      g_d1    <= bus.neuron;
      g_d2    <= g_d1;
    end
  end

  // Per-lane saturating accumulate, then leak/integrate/fire on the result so
  // a weight landing in the activation cycle is included.
  always_comb begin
    spike = '0;
    for (int k = 0; k < EC_SIZE; k++) begin
      if (acc_vld)
        acc_wide[k] = (MEM_WIDTH+1)'(acc_q[k])
                    + (MEM_WIDTH+1)'($signed(bus.w_data[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      else
        acc_wide[k] = (MEM_WIDTH+1)'(acc_q[k]);

      if (acc_wide[k] > (MEM_WIDTH+1)'(MEM_MAX))
        acc_sum[k] = MEM_MAX;
      else if (acc_wide[k] < (MEM_WIDTH+1)'(MEM_MIN))
        acc_sum[k] = MEM_MIN;
      else
        acc_sum[k] = acc_wide[k][MEM_WIDTH-1:0];

      v_wide[k] = (MEM_WIDTH+2)'(v_q[k])
                - (MEM_WIDTH+2)'(v_q[k] >>> LEAK_SHIFT)
                + (MEM_WIDTH+2)'(acc_sum[k]);

      if (v_wide[k] > (MEM_WIDTH+2)'(MEM_MAX))
        v_sat[k] = MEM_MAX;
      else if (v_wide[k] < (MEM_WIDTH+2)'(MEM_MIN))
        v_sat[k] = MEM_MIN;
      else
        v_sat[k] = v_wide[k][MEM_WIDTH-1:0];

      if (v_sat[k] >= THR) begin
        spike[k]  = 1'b1;
        v_fire[k] = v_sat[k] - THR;
      end else begin
        v_fire[k] = v_sat[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < EC_SIZE; k++) begin
        acc_q[k] <= '0;
        v_q[k]   <= '0;
      end
      bus.post_syn_spk   <= '0;
      bus.total_out_spks <= '0;
    end else begin
      for (int k = 0; k < EC_SIZE; k++) begin
        if (activ_d[1]) begin
          acc_q[k] <= '0;
          // Last activation of the group hands the next group a clean membrane.
          v_q[k]   <= last_d[1] ? '0 : v_fire[k];
        end else begin
          acc_q[k] <= acc_sum[k];
        end
      end
      bus.post_syn_spk <= activ_d[1] ? spike : '0;
      if (activ_d[1])
        bus.total_out_spks <= bus.total_out_spks + 32'($countones(spike));
    end
  end

  // Out-of-range time step or group still runs LIF but never touches the buffer.
  assign buf_wr = activ_d[1]
                && ({1'b0, t_d2} < (TW+1)'(TIME_STEPS))
                && ({1'b0, g_d2} < (NW+1)'(NGROUPS));
  assign wr_row = t_d2[RAW-1:0];
  assign wr_grp = g_d2[GW-1:0];
  assign rd_in_range = {1'b0, bus.spk_out_rd_addr} < (RAW+1)'(TIME_STEPS);

  // Read and write share the edge, so a same-cycle read of the row being
  // written returns its previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < TIME_STEPS; r++)
        spk_buf[r] <= '0;
      bus.spk_out_train <= '0;
    end else begin
      if (buf_wr)
        spk_buf[wr_row][wr_grp*EC_SIZE +: EC_SIZE] <= spike;
      if (bus.spk_out_rd_en)
        bus.spk_out_train <= rd_in_range ? spk_buf[bus.spk_out_rd_addr] : '0;
    end
  end

  // Loaded edge is held back three cycles so the last activation has landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_prev              <= 1'b0;
      ld_pipe              <= '0;
      bus.layer_spks_ready <= 1'b0;
    end else begin
      ld_prev              <= bus.post_syn_RAM_loaded;
      ld_pipe              <= {ld_pipe[0], bus.post_syn_RAM_loaded & ~ld_prev};
      bus.layer_spks_ready <= bus.layer_spks_ready | ld_pipe[1];
    end
  end
endmodule
